// File: rtl/cuenta_ciclos_param.sv
// Cycle/event counter with start/busy/done handshake, run-time limit, prescaler and
// three count modes: one-shot up (00/11), wrap-around up (01) and one-shot down (10).
module cuenta_ciclos_param #(
  parameter int WIDTH     = 9,
  parameter int DEF_LIMIT = 291,
  parameter int PRESC_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic [1:0]         modo,
  input  logic [WIDTH-1:0]   limite,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   salida,
  output logic               ocupado,
  output logic               fin
);

  if (DEF_LIMIT >= (1 << WIDTH)) begin : g_def_limit_check
    $error("cuenta_ciclos_param: DEF_LIMIT does not fit in WIDTH bits");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   salida_next;
  logic [WIDTH-1:0]   lim_q, lim_next, lim_sel;
  logic [1:0]         modo_q, modo_next;
  logic [PRESC_W-1:0] presc_q, presc_next;
  logic [PRESC_W-1:0] pc, pc_next;
  logic               fin_next;
  logic               tick;

  assign tick    = (pc == presc_q);
  assign lim_sel = (limite == '0) ? WIDTH'(DEF_LIMIT) : limite;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      salida  <= '0;
      pc      <= '0;
      fin     <= 1'b0;
      lim_q   <= '0;
      modo_q  <= '0;
      presc_q <= '0;
    end else begin
      state   <= state_next;
      salida  <= salida_next;
      pc      <= pc_next;
      fin     <= fin_next;
      lim_q   <= lim_next;
      modo_q  <= modo_next;
      presc_q <= presc_next;
    end
  end

  // Priority: en low clears everything, then start (outside RUN), then prescaled ticks.
  always_comb begin
    state_next  = state;
    salida_next = salida;
    pc_next     = pc;
    fin_next    = 1'b0;
    lim_next    = lim_q;
    modo_next   = modo_q;
    presc_next  = presc_q;

    if (!en) begin
      state_next  = IDLE;
      salida_next = '0;
      pc_next     = '0;
    end else if (start && (state != RUN)) begin
      state_next  = RUN;
      lim_next    = lim_sel;
      modo_next   = modo;
      presc_next  = presc;
      salida_next = (modo == 2'b10) ? lim_sel : '0;
      pc_next     = '0;
    end else if (state == RUN) begin
      if (tick) begin
        pc_next = '0;
        case (modo_q)
          2'b01: begin
            if (salida == lim_q) begin
              salida_next = '0;
              fin_next    = 1'b1;
            end else begin
              salida_next = salida + WIDTH'(1);
            end
          end
          2'b10: begin
            salida_next = salida - WIDTH'(1);
            if (salida == WIDTH'(1)) begin
              fin_next   = 1'b1;
              state_next = HOLD;
            end
          end
          default: begin
            salida_next = salida + WIDTH'(1);
            if (salida == lim_q - WIDTH'(1)) begin
              fin_next   = 1'b1;
              state_next = HOLD;
            end
          end
        endcase
      end else begin
        pc_next = pc + PRESC_W'(1);
      end
    end
  end

  always_comb begin
    ocupado = (state == RUN);
  end

endmodule
